inta_sequencer: RTL
===================

# inta_sequencer

Interrupt-acknowledge sequencer and in-service register for the 8259A-style controller. Sits directly downstream of the priority resolver. It takes the resolver's one-hot winning request and raises INT to the CPU. It runs the two-pulse INTA handshake, clears the serviced IRR bit, maintains the in-service register and processes EOI commands. It feeds `isr` and `highest_level_in_service` back to the resolver.

## Interface
- No parameters; width fixed at 8 levels.
- `clk` input 1: sole clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `interrupt` input 8: one-hot winning request from the priority resolver; 0 = none.
- `intack` input 1: CPU acknowledge, active-high, already synchronised to `clk`.
- `vector_base` input 5: ICW2 bits [7:3].
- `auto_eoi` input 1: clear ISR bit at the end of the second INTA.
- `auto_rotate` input 1: rotate priority on auto-EOI.
- `eoi_valid` input 1: one-cycle OCW2 EOI strobe.
- `eoi_specific` input 1: 1 = use `eoi_level`; 0 = non-specific.
- `eoi_rotate` input 1: rotate priority with this EOI.
- `eoi_level` input 3: level for a specific EOI.
- `int_out` output 1: interrupt to CPU.
- `clear_irr` output 8: one-cycle one-hot pulse clearing an IRR bit.
- `isr` output 8: in-service register.
- `highest_level_in_service` output 8: one-hot lowest-priority level for the resolver; 0 = fixed priority.
- `vector_out` output 8: `{vector_base, level}`.
- `vector_valid` output 1: `vector_out` is being driven on the bus.

## Operation
- Reset values: all outputs 0. State is IDLE. Latched level is 7.
- INTA edge detection: `ack_edge` = `intack` high while the registered previous `intack` is low.
- State machine:
  - IDLE -> REQ when `interrupt != 0`. `int_out` is 1 in REQ and ACK1.
  - REQ -> IDLE if `interrupt` returns to 0 before an `ack_edge`; `int_out` drops.
  - REQ -> ACK1 on `ack_edge`:
    - latch the encoded level L of `interrupt`;
    - set `isr[L]`;
    - pulse `clear_irr[L]` for one cycle.
  - If `ack_edge` occurs while `interrupt == 0` (spurious): L = 7, with no ISR set and no `clear_irr`.
  - ACK1 -> ACK2 on the next `ack_edge`:
    - `vector_out` = `{vector_base, L}`;
    - `vector_valid` = 1 while `intack` stays high;
    - `int_out` = 0.
    - If `auto_eoi` and the request was not spurious, clear `isr[L]`. If `auto_rotate` is also set, `highest_level_in_service` becomes one-hot L.
  - ACK2 -> IDLE when `intack` falls; `vector_valid` drops.
  - `ack_edge` in IDLE is ignored.
- EOI handling, independent of state:
  - Specific EOI clears `isr[eoi_level]`.
  - Non-specific EOI clears the highest-priority set ISR bit. Priority is scanned from the level after the `highest_level_in_service` position, wrapping mod 8; bit 0 is highest when that register is 0.
  - With `eoi_rotate`, `highest_level_in_service` becomes one-hot of the cleared level.
  - Non-specific EOI with `isr == 0` is a no-op.
- Simultaneous EOI and ISR set in the same cycle: apply the clear first, then the set. The set wins on the same bit.

## Timing
- `ack_edge` detected in cycle N; `isr` and `clear_irr` updated at the edge ending N, visible in N+1.
- `clear_irr` is high exactly one cycle.
- Second `ack_edge` in cycle M: `vector_out` and `vector_valid` visible in M+1; `isr` AEOI clear also visible in M+1.
- `int_out` rises the cycle after `interrupt` becomes non-zero while in IDLE.
- Resolver path is combinational, so a new `interrupt` appears the same cycle `isr` changes.
- `reset` mid-handshake aborts to IDLE with reset values next cycle.
- `vector_out` holds its last value when `vector_valid` is 0.

## Structure
- Shared package `pic_pkg`:
  - state enum (IDLE/REQ/ACK1/ACK2);
  - `NUM_LEVELS` = 8;
  - spurious level constant 7;
  - functions `onehot_to_level` and `level_to_onehot`.
- One natural sub-module: `isr_priority_scan`, combinational. It finds the highest-priority set ISR bit relative to `highest_level_in_service` for non-specific EOI.

## Test plan
- `interrupt` = 8'h04, two `intack` pulses, `vector_base` = 5'h11:
  - `int_out` = 1;
  - `clear_irr` = 8'h04 for one cycle;
  - `isr` = 8'h04;
  - `vector_out` = 8'h8A;
  - non-specific EOI afterwards gives `isr` = 0.
- `auto_eoi` = 1, `auto_rotate` = 1, `interrupt` = 8'h20, full handshake: `isr` = 0 after the second INTA; `highest_level_in_service` = 8'h20.
- `interrupt` = 8'h01 withdrawn before INTA, then an INTA edge arrives: spurious path gives `vector_out` = `{vector_base, 3'd7}`, with no `clear_irr` and `isr` unchanged.
- `isr` = 8'h0A, `highest_level_in_service` = 8'h02, non-specific EOI: clears bit 3, giving `isr` = 8'h02.
- Specific EOI `eoi_level` = 1 in the same cycle as the first INTA for level 1: `isr[1]` = 1 afterwards.
- `reset` asserted in ACK1: next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package pic_pkg;

  localparam int NUM_LEVELS = 8;

  // Level reported to the CPU when INTA arrives with no request pending.
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK1,
    ACK2
  } state_t;

  // Encodes a one-hot request to its level; an empty vector maps to the
  // spurious level so callers get the right answer without a special case.
  function automatic logic [2:0] onehot_to_level(input logic [7:0] oh);
    logic [2:0] lvl;
    lvl = SPURIOUS_LEVEL;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (oh[i]) lvl = 3'(i);
    end
    return lvl;
  endfunction

  function automatic logic [7:0] level_to_onehot(input logic [2:0] lvl);
    return 8'b0000_0001 << lvl;
  endfunction

endpackage

// File: rtl/isr_priority_scan.sv
// Finds the highest-priority in-service level under the current rotation.
// Latency: combinational.
// Backpressure: none.
module isr_priority_scan
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  logic [7:0] highest_level_in_service,
  output logic       found,
  output logic [2:0] level
);

  logic [2:0] start;

  // Scan upward from the level just after the lowest-priority marker,
  // wrapping mod 8; with no marker, level 0 is the highest priority.
  always_comb begin
    start = (highest_level_in_service == 8'h00) ? 3'd0
          : onehot_to_level(highest_level_in_service) + 3'd1;
    found = |isr;
    level = 3'd0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (isr[start + 3'(i)]) level = start + 3'(i);
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// INT/INTA handshake sequencer with in-service register and EOI handling.
// Latency: INT one cycle after a request; ISR/clear_irr and vector one cycle after each INTA edge.
// Backpressure: none; the CPU paces the handshake through intack.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       intack,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       auto_rotate,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] clear_irr,
  output logic [7:0] isr,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  state_t     state;
  logic       intack_q;
  logic [2:0] level_q;
  logic       spurious_q;

  logic       ack_edge;
  logic       take_ack;
  logic       finish_ack;
  logic       scan_found;
  logic [2:0] scan_level;
  logic [7:0] isr_clr;
  logic [7:0] isr_set;
  logic [7:0] hlis_nxt;

  assign ack_edge   = intack & ~intack_q;
  assign take_ack   = (state == REQ)  && ack_edge;
  assign finish_ack = (state == ACK1) && ack_edge;

  isr_priority_scan u_scan (
    .isr                      (isr),
    .highest_level_in_service (highest_level_in_service),
    .found                    (scan_found),
    .level                    (scan_level)
  );

  // Gather this cycle's ISR clears/sets and the next rotation marker;
  // an explicit EOI rotation overrides an auto-EOI rotation in the same cycle.
  always_comb begin
    isr_clr  = 8'h00;
    isr_set  = 8'h00;
    hlis_nxt = highest_level_in_service;
    if (finish_ack && auto_eoi && !spurious_q) begin
      isr_clr = isr_clr | level_to_onehot(level_q);
      if (auto_rotate) hlis_nxt = level_to_onehot(level_q);
    end
    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_clr = isr_clr | level_to_onehot(eoi_level);
        if (eoi_rotate) hlis_nxt = level_to_onehot(eoi_level);
      end else if (scan_found) begin
        isr_clr = isr_clr | level_to_onehot(scan_level);
        if (eoi_rotate) hlis_nxt = level_to_onehot(scan_level);
      end
    end
    if (take_ack && interrupt != 8'h00) begin
      isr_set = level_to_onehot(onehot_to_level(interrupt));
    end
  end

  // Handshake FSM with registered INT, IRR-clear pulse and vector outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      intack_q     <= 1'b0;
      level_q      <= SPURIOUS_LEVEL;
      spurious_q   <= 1'b0;
      int_out      <= 1'b0;
      clear_irr    <= 8'h00;
      vector_out   <= 8'h00;
      vector_valid <= 1'b0;
    end else begin
      intack_q  <= intack;
      clear_irr <= 8'h00;
      case (state)
        IDLE: begin
          if (interrupt != 8'h00) begin
            state   <= REQ;
            int_out <= 1'b1;
          end
        end
        REQ: begin
          // An INTA edge wins over a withdrawn request: that is the spurious path.
          if (ack_edge) begin
            state      <= ACK1;
            level_q    <= onehot_to_level(interrupt);
            spurious_q <= (interrupt == 8'h00);
            if (interrupt != 8'h00) begin
              clear_irr <= level_to_onehot(onehot_to_level(interrupt));
            end
          end else if (interrupt == 8'h00) begin
            state   <= IDLE;
            int_out <= 1'b0;
          end
        end
        ACK1: begin
          if (ack_edge) begin
            state        <= ACK2;
            int_out      <= 1'b0;
            vector_out   <= {vector_base, level_q};
            vector_valid <= 1'b1;
          end
        end
        ACK2: begin
          if (!intack) begin
            state        <= IDLE;
            vector_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-service register and rotation marker; a set beats a clear on the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      isr                      <= 8'h00;
      highest_level_in_service <= 8'h00;
    end else begin
      isr                      <= (isr & ~isr_clr) | isr_set;
      highest_level_in_service <= hlis_nxt;
    end
  end

endmodule
